id_ex_latch: RTL and testbench

- Pipeline register between decode (register-file read) and execute.
- Captures decoded instruction and operand values, applies operand forwarding from MEM and WB, detects load-use hazards, and presents a valid/ready handshake on both sides.
- Consumes src1/src2 from the register file; produces the EX-stage operand bundle.

---
 rtl/id_ex_latch.sv | 128 ++++++++++++
 tb/tb_id_ex_latch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register: MEM/WB operand forwarding, load-use stall, valid/ready on both sides.
// Optional: define ID_EX_STALL_CNT_EN to build the saturating load-use stall counter (stall_cnt).
module id_ex_latch #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [XLEN-1:0]   id_src1,
  input  logic [XLEN-1:0]   id_src2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_is_load,
  input  logic              mem_fwd_valid,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_is_load,
  output logic [31:0]       stall_cnt
);

  logic              ex_valid_reg;
  logic [XLEN-1:0]   ex_pc_reg;
  logic [XLEN-1:0]   ex_op1_reg;
  logic [XLEN-1:0]   ex_op2_reg;
  logic [XLEN-1:0]   ex_imm_reg;
  logic [REG_AW-1:0] ex_rd_reg;
  logic [CTRL_W-1:0] ex_ctrl_reg;
  logic              ex_is_load_reg;

  logic [1:0][REG_AW-1:0] rs_idx;
  logic [1:0][XLEN-1:0]   src_val;
  logic [1:0][XLEN-1:0]   op_fwd;
  logic                   hz;
  logic                   id_ready_int;

  assign rs_idx  = {id_rs2, id_rs1};
  assign src_val = {id_src2, id_src1};

  // MEM is younger than WB, so it wins; x0 is hardwired zero and never forwarded.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign op_fwd[gi] =
        (rs_idx[gi] == '0)                                ? '0           :
        (mem_fwd_valid && (mem_fwd_rd == rs_idx[gi]))     ? mem_fwd_data :
        (wb_fwd_valid  && (wb_fwd_rd  == rs_idx[gi]))     ? wb_fwd_data  :
                                                            src_val[gi];
    end
  endgenerate

  assign hz = id_valid && ex_valid_reg && ex_is_load_reg && (ex_rd_reg != '0) &&
              ((ex_rd_reg == id_rs1) || (ex_rd_reg == id_rs2));

  assign id_ready_int = !flush && !hz && (!ex_valid_reg || ex_ready);
  assign id_ready     = id_ready_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_pc_reg      <= '0;
      ex_op1_reg     <= '0;
      ex_op2_reg     <= '0;
      ex_imm_reg     <= '0;
      ex_rd_reg      <= '0;
      ex_ctrl_reg    <= '0;
      ex_is_load_reg <= 1'b0;
    end else if (flush) begin
      ex_valid_reg <= 1'b0;
    end else if (id_valid && id_ready_int) begin
      ex_valid_reg   <= 1'b1;
      ex_pc_reg      <= id_pc;
      ex_op1_reg     <= op_fwd[0];
      ex_op2_reg     <= op_fwd[1];
      ex_imm_reg     <= id_imm;
      ex_rd_reg      <= id_rd;
      ex_ctrl_reg    <= id_ctrl;
      ex_is_load_reg <= id_is_load;
    end else if (ex_valid_reg && ex_ready) begin
      // Consumed with nothing accepted behind it; under a load-use hazard this is the bubble.
      ex_valid_reg <= 1'b0;
    end
  end

  assign ex_valid   = ex_valid_reg;
  assign ex_pc      = ex_pc_reg;
  assign ex_op1     = ex_op1_reg;
  assign ex_op2     = ex_op2_reg;
  assign ex_imm     = ex_imm_reg;
  assign ex_rd      = ex_rd_reg;
  assign ex_ctrl    = ex_ctrl_reg;
  assign ex_is_load = ex_is_load_reg;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (hz && !flush && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// Self-checking bench for id_ex_latch: scoreboard of expected EX slots pushed on accept, popped one cycle later.
module tb_id_ex_latch;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready;
  logic [31:0] id_pc, id_src1, id_src2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [15:0] id_ctrl;
  logic        id_is_load;
  logic        mem_fwd_valid, wb_fwd_valid;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_ready, ex_is_load;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm, stall_cnt;
  logic [4:0]  ex_rd;
  logic [15:0] ex_ctrl;

  id_ex_latch dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_src1(id_src1), .id_src2(id_src2),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_is_load(id_is_load),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic [15:0] ctrl;
    logic        is_load;
  } slot_t;

  slot_t       sb_q[$];
  slot_t       last;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_stall = '0;

`ifdef ID_EX_STALL_CNT_EN
  localparam logic [31:0] CNT_STEP = 32'd1;
`else
  localparam logic [31:0] CNT_STEP = 32'd0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd_model(input logic [4:0] rs, input logic [31:0] src);
    if (rs == 5'd0) return 32'd0;
    if (mem_fwd_valid && mem_fwd_rd == rs) return mem_fwd_data;
    if (wb_fwd_valid && wb_fwd_rd == rs) return wb_fwd_data;
    return src;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic wv, input logic [4:0] wr, input logic [31:0] wd);
    mem_fwd_valid = mv; mem_fwd_rd = mr; mem_fwd_data = md;
    wb_fwd_valid  = wv; wb_fwd_rd  = wr; wb_fwd_data  = wd;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic [15:0] ctrl, input logic ld);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_src1 = s1; id_src2 = s2;
    id_rd = rd; id_imm = imm; id_ctrl = ctrl; id_is_load = ld;
  endtask

  task automatic check_slot(input string tag);
    slot_t e;
    check({tag, " ex_valid"}, ex_valid, 1);
    if (sb_q.size() == 0) begin
      check({tag, " sb_nonempty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " pc"},   ex_pc,      e.pc);
      check({tag, " op1"},  ex_op1,     e.op1);
      check({tag, " op2"},  ex_op2,     e.op2);
      check({tag, " imm"},  ex_imm,     e.imm);
      check({tag, " rd"},   ex_rd,      e.rd);
      check({tag, " ctrl"}, ex_ctrl,    e.ctrl);
      check({tag, " load"}, ex_is_load, e.is_load);
      last = e;
      $display("txn %s pc=%08h op1=%08h op2=%08h rd=%0d ld=%0b", tag, ex_pc, ex_op1, ex_op2, ex_rd, ex_is_load);
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, " pc"},   ex_pc,      last.pc);
    check({tag, " op1"},  ex_op1,     last.op1);
    check({tag, " op2"},  ex_op2,     last.op2);
    check({tag, " rd"},   ex_rd,      last.rd);
    check({tag, " load"}, ex_is_load, last.is_load);
  endtask

  // Accept the instruction currently presented on ID: ready expected, slot compared after one edge.
  task automatic accept(input string tag);
    #1;
    check({tag, " id_ready"}, id_ready, 1);
    sb_q.push_back('{pc: id_pc, op1: fwd_model(id_rs1, id_src1), op2: fwd_model(id_rs2, id_src2),
                     imm: id_imm, rd: id_rd, ctrl: id_ctrl, is_load: id_is_load});
    step();
    check_slot(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    step(); step();
    check("rst ex_valid", ex_valid, 0);
    check("rst ex_pc", ex_pc, 0);
    check("rst ex_op1", ex_op1, 0);
    check("rst ex_ctrl", ex_ctrl, 0);
    check("rst stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    step();

    // Forwarding priority and x0
    set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
    drive(32'h100, 3, 0, 32'h11, 32'h22, 7, 32'h5, 16'h1234, 0);
    accept("fwd_mem");
    check("fwd_mem op1 value", ex_op1, 32'hAA);
    set_fwd(0, 3, 32'hAA, 1, 3, 32'hBB);
    drive(32'h104, 3, 0, 32'h11, 32'h22, 7, 32'h6, 16'h1235, 0);
    accept("fwd_wb");
    check("fwd_wb op1 value", ex_op1, 32'hBB);
    set_fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
    drive(32'h108, 0, 4, 32'h11, 32'h44, 7, 32'h7, 16'h1236, 0);
    accept("fwd_x0");
    check("fwd_x0 op1 value", ex_op1, 0);

    // Back-to-back random stream, no loads
    for (int i = 0; i < 8; i++) begin
      set_fwd($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
      drive(32'h200 + 32'(i * 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, 5'($urandom_range(1, 31)), $urandom, 16'($urandom), 0);
      accept("b2b");
    end

    // Load-use hazard -> bubble, then accept with MEM forwarding
    set_fwd(0, 0, 0, 0, 0, 0);
    drive(32'h300, 1, 2, 32'h1, 32'h2, 5, 32'h0, 16'h0010, 1);
    accept("load");
    drive(32'h304, 6, 5, 32'h66, 32'h999, 8, 32'h4, 16'h0020, 0);
    #1;
    check("hz id_ready", id_ready, 0);
    step();
    exp_stall = exp_stall + CNT_STEP;
    check("hz bubble ex_valid", ex_valid, 0);
    check("hz stall_cnt", stall_cnt, exp_stall);
    set_fwd(1, 5, 32'h1234, 0, 0, 0);
    accept("after_hz");
    check("after_hz op2 value", ex_op2, 32'h1234);
    check("after_hz stall_cnt", stall_cnt, exp_stall);

    // Load to x0 must not stall
    set_fwd(0, 0, 0, 0, 0, 0);
    drive(32'h310, 1, 2, 32'h1, 32'h2, 0, 32'h0, 16'h0030, 1);
    accept("load_x0");
    drive(32'h314, 0, 0, 32'h7, 32'h8, 9, 32'h1, 16'h0040, 0);
    accept("no_hz_x0");
    check("no_hz_x0 stall_cnt", stall_cnt, exp_stall);

    // EX backpressure: slot held, no re-forwarding, then simultaneous consume+accept
    ex_ready = 1'b0;
    drive(32'h320, 3, 0, 32'h33, 32'h0, 10, 32'h2, 16'h0050, 0);
    for (int i = 0; i < 3; i++) begin
      set_fwd(1, 3, 32'h5500 + 32'(i), 0, 0, 0);
      #1;
      check("hold id_ready", id_ready, 0);
      step();
      check("hold ex_valid", ex_valid, 1);
      check_held("hold");
    end
    ex_ready = 1'b1;
    accept("release");

    // Flush with a hazard present: slot killed, payload kept, counter untouched
    set_fwd(0, 0, 0, 0, 0, 0);
    drive(32'h400, 0, 0, 32'h0, 32'h0, 9, 32'h0, 16'h0060, 1);
    accept("load_fl");
    drive(32'h404, 9, 0, 32'h99, 32'h0, 11, 32'h3, 16'h0070, 0);
    flush = 1'b1;
    #1;
    check("flush id_ready", id_ready, 0);
    step();
    check("flush ex_valid", ex_valid, 0);
    check_held("flush");
    check("flush stall_cnt", stall_cnt, exp_stall);
    flush = 1'b0;
    accept("after_flush");

    // Asynchronous reset mid-stream
    drive(32'h500, 1, 2, 32'h5, 32'h6, 12, 32'h9, 16'h0080, 0);
    accept("pre_rst");
    id_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst ex_valid", ex_valid, 0);
    check("arst ex_pc", ex_pc, 0);
    check("arst ex_op1", ex_op1, 0);
    check("arst ex_op2", ex_op2, 0);
    check("arst ex_imm", ex_imm, 0);
    check("arst ex_rd", ex_rd, 0);
    check("arst ex_ctrl", ex_ctrl, 0);
    check("arst ex_is_load", ex_is_load, 0);
    check("arst stall_cnt", stall_cnt, 0);
    step();
    rst = 1'b0;
    step();
    check("end ex_valid", ex_valid, 0);
    check("end sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
